// File: rtl/ama_riscv_defines.sv
// Shared register-file constants and the reg-dump FSM state encoding.
package ama_riscv_defines;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int REG_NUM    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } dump_state_t;

endpackage

// File: rtl/ama_riscv_reg_dump.sv
// Register file read-out engine: sweeps addresses 0..REG_NUM-1 and streams {addr, data} beats.
// Define AMA_RISCV_REG_DUMP_CSUM_EN to append an XOR checksum beat after the last register.
module ama_riscv_reg_dump
    import ama_riscv_defines::*;
#(
    parameter int DW = DATA_WIDTH,
    parameter int AW = ADDR_WIDTH,
    parameter int RN = REG_NUM
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          out_csum,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0] LAST_IDX = (AW+1)'(RN - 1);

    dump_state_t   state, state_nx;
    logic [AW:0]   idx, idx_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] data_nx;
    logic          valid_nx, last_nx, done_nx, csum_flag_nx;
    logic          capture;
    logic          csum_flag;

`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
    logic [DW-1:0] csum, csum_nx;
`endif

    assign rf_addr = idx[AW-1:0];
    assign busy    = (state != IDLE);

    always_comb begin
        state_nx     = state;
        idx_nx       = idx;
        addr_nx      = out_addr;
        data_nx      = out_data;
        last_nx      = out_last;
        valid_nx     = out_valid;
        csum_flag_nx = csum_flag;
        done_nx      = 1'b0;
        capture      = 1'b0;
`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
        csum_nx      = csum;
`endif
        case (state)
            IDLE: begin
                // a start coinciding with the done pulse is dropped
                if (start && !done) begin
                    state_nx = LOAD;
                    idx_nx   = '0;
`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
                    csum_nx  = '0;
`endif
                end
            end
            LOAD: begin
                capture  = 1'b1;
                state_nx = SEND;
            end
            SEND: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        valid_nx     = 1'b0;
                        last_nx      = 1'b0;
                        csum_flag_nx = 1'b0;
                        done_nx      = 1'b1;
                        state_nx     = IDLE;
`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
                    end else if (idx == LAST_IDX + 1'b1) begin
                        addr_nx      = '0;
                        data_nx      = csum;
                        last_nx      = 1'b1;
                        csum_flag_nx = 1'b1;
`endif
                    end else begin
                        capture = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        if (capture) begin
            addr_nx      = idx[AW-1:0];
            data_nx      = rf_data;
            valid_nx     = 1'b1;
            csum_flag_nx = 1'b0;
            idx_nx       = idx + 1'b1;
`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
            last_nx      = 1'b0;
            csum_nx      = csum ^ rf_data;
`else
            last_nx      = (idx == LAST_IDX);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            csum_flag <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            idx       <= idx_nx;
            out_valid <= valid_nx;
            out_addr  <= addr_nx;
            out_data  <= data_nx;
            out_last  <= last_nx;
            csum_flag <= csum_flag_nx;
            done      <= done_nx;
        end
    end

`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum <= '0;
        else     csum <= csum_nx;
    end
    assign out_csum = csum_flag;
`else
    assign out_csum = 1'b0;
`endif

endmodule

// File: tb/tb_ama_riscv_reg_dump.sv
// Self-checking bench for ama_riscv_reg_dump: scenario table plus reset/latency/writeback sequences.
module tb_ama_riscv_reg_dump;
    import ama_riscv_defines::*;

`ifdef AMA_RISCV_REG_DUMP_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif
    localparam int NBEATS = REG_NUM + (CSUM ? 1 : 0);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;
    logic                  out_valid, out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last, out_csum, busy, done;

    logic [DATA_WIDTH-1:0] rf [REG_NUM];
    assign rf_data = rf[rf_addr];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ama_riscv_reg_dump dut (
        .clk(clk), .rst(rst), .start(start),
        .rf_addr(rf_addr), .rf_data(rf_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .out_last(out_last), .out_csum(out_csum),
        .busy(busy), .done(done)
    );

    // scenario record: stimulus knobs plus expected done-pulse count
    typedef struct {
        int rmode;       // 0 always ready, 1 pattern 1,0,0,1, 2 random
        int preload;     // 0 0x1000_0000+i, 1 i, 2 random, 3 i with x5=all ones
        int restart_at;  // beat index at which start is re-pulsed, -1 none
        int wb_at;       // beat index at which x20 is overwritten, -1 none
        int rst_at;      // beat index at which reset is pulsed, -1 none
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic preload(input int mode);
        for (int i = 0; i < REG_NUM; i++) begin
            case (mode)
                0:       rf[i] = 32'h1000_0000 + i;
                1, 3:    rf[i] = i;
                default: rf[i] = $urandom;
            endcase
        end
        if (mode == 3) rf[5] = 32'hFFFF_FFFF;
        rf[0] = '0;
    endtask

    // reference beat: register i for i < REG_NUM, else XOR of the whole file
    function automatic logic [DATA_WIDTH+ADDR_WIDTH+1:0] exp_beat(input int i);
        logic [DATA_WIDTH-1:0] x;
        x = '0;
        if (i < REG_NUM)
            return {ADDR_WIDTH'(i), rf[i], (i == REG_NUM-1) && !CSUM, 1'b0};
        for (int k = 0; k < REG_NUM; k++) x ^= rf[k];
        return {ADDR_WIDTH'(0), x, 1'b1, 1'b1};
    endfunction

    task automatic run_sweep(input vec_t v);
        int beats, dcnt, last_acc;
        bit stall, restarted;
        logic [DATA_WIDTH+ADDR_WIDTH+1:0] held, cur;
        beats = 0; dcnt = 0; last_acc = -10; stall = 0; restarted = 0; held = '0;
        @(negedge clk); start = 1'b1; out_ready = 1'b0;
        @(negedge clk); start = 1'b0;
        chk("latency_no_valid_yet", {63'd0, out_valid}, 64'd0);
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            cur = {out_addr, out_data, out_last, out_csum};
            if (cyc == 0) chk("first_valid_latency", {63'd0, out_valid}, 64'd1);
            if (stall) chk("stall_stable", {63'd0, out_valid, cur}, {63'd0, 1'b1, held});
            if (done) begin
                dcnt++;
                chk("done_timing", 64'(cyc), 64'(last_acc + 1));
            end
            if (beats == NBEATS && cyc >= last_acc + 3) break;
            if (v.rst_at >= 0 && beats == v.rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_clears", {62'd0, out_valid, busy}, 64'd0);
                @(negedge clk); rst = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (done || busy || out_valid) dcnt++;
                end
                chk("rst_mid_no_done", 64'(dcnt), 64'(v.exp_done));
                return;
            end
            case (v.rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = 1'b0;
            if (v.restart_at >= 0 && beats == v.restart_at && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (v.wb_at >= 0 && beats == v.wb_at) rf[20] = 32'hDEAD_BEEF;
            if (out_valid && out_ready) begin
                chk($sformatf("beat_%0d", beats), 64'(cur), 64'(exp_beat(beats)));
                beats++;
                last_acc = cyc;
            end
            stall = out_valid && !out_ready;
            held  = cur;
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk("beat_count", 64'(beats), 64'(NBEATS));
        chk("done_count", 64'(dcnt), 64'(v.exp_done));
        chk("idle_after_sweep", {62'd0, busy, out_valid}, 64'd0);
    endtask

    vec_t vecs [8];

    initial begin
        logic [DATA_WIDTH-1:0] csum_seen;
        vecs[0] = '{0, 0, -1, -1, -1, 1};
        vecs[1] = '{1, 0, -1, -1, -1, 1};
        vecs[2] = '{0, 0, 10, -1, -1, 1};
        vecs[3] = '{0, 0, -1, -1, 5, 0};
        vecs[4] = '{0, 0, -1, -1, -1, 1};
        vecs[5] = '{0, 1, -1, -1, -1, 1};
        vecs[6] = '{0, 3, -1, 5, -1, 1};
        vecs[7] = '{2, 2, NBEATS, -1, -1, 1};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        preload(0);
        repeat (2) @(negedge clk);
        chk("reset_outputs", {out_valid, out_addr, out_data, out_last, out_csum, busy, done, rf_addr},
            '0);
        rst = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_no_valid_idle", {62'd0, busy, out_valid}, 64'd0);

        foreach (vecs[i]) begin
            preload(vecs[i].preload);
            run_sweep(vecs[i]);
            if (vecs[i].wb_at >= 0) chk("writeback_x20", 64'(rf[20]), 64'hDEAD_BEEF);
        end

        // checksum constants: XOR(0..31)=0, and with x5 forced to all ones
        if (CSUM) begin
            preload(3);
            csum_seen = '1;
            @(negedge clk); start = 1'b1; out_ready = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (out_valid && out_csum) begin csum_seen = out_data; break; end
            end
            chk("csum_x5_ones", 64'(csum_seen), 64'hFFFF_FFFA);
            repeat (4) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
